// File: rtl/program_feeder.sv
// program_feeder: packs a byte-stream program into word memory and replays
// it as one instruction per clock for the 16-bit core.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   load_start         pulse, begins a new program load
//   load_valid/ready   byte handshake, load_data high byte of a word first
//   load_last          final byte of the program, qualified by load_valid
//   run                pulse, start execution from word 0
//   instruction        word presented to the core
//   instr_valid        instruction is a program word rather than filler
//   halted             stopped on a HLT word (only with halt detect)
//   prog_len           words stored by the last load (saturates at DEPTH)
//   overflow           the last load supplied more than DEPTH words
//
// Build option: define FEEDER_HALT_DETECT_EN to freeze on HLT (opcode 4).
module program_feeder #(
    parameter int N     = 16,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [7:0]    load_data,
    input  logic          load_last,
    output logic          load_ready,
    input  logic          run,
    output logic [N-1:0]  instruction,
    output logic          instr_valid,
    output logic          halted,
    output logic [AW:0]   prog_len,
    output logic          overflow
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        HALT,
        DONE
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    state_t        state_q, state_d;
    logic          ready_q, ready_d;
    logic [N-1:0]  instr_q, instr_d;
    logic          valid_q, valid_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   fetch_pc_q, fetch_pc_d;
    logic          ovf_q, ovf_d;
    logic          phase_q, phase_d;
    logic [7:0]    hi_q, hi_d;

    logic [N-1:0]  mem_q [DEPTH];
    logic          word_done;
    logic          mem_we;
    logic [N-1:0]  mem_wdata;
    logic          start_load;
    logic          start_run;

`ifdef FEEDER_HALT_DETECT_EN
    logic          halted_q, halted_d;
`endif

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        wr_ptr_d   = wr_ptr_q;
        fetch_pc_d = fetch_pc_q;
        ovf_d      = ovf_q;
        phase_d    = phase_q;
        hi_d       = hi_q;
        word_done  = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;

        // load_start outranks run; both are ignored while loading
        start_load = load_start && (state_q != LOAD);
        start_run  = run && !load_start && (state_q != LOAD);

        if (start_load) begin
            state_d  = LOAD;
            ready_d  = 1'b1;
            instr_d  = '0;
            valid_d  = 1'b0;
            wr_ptr_d = '0;
            phase_d  = 1'b0;
            ovf_d    = 1'b0;
        end else if (start_run) begin
            instr_d    = '0;
            valid_d    = 1'b0;
            fetch_pc_d = '0;
            state_d    = (wr_ptr_q == '0) ? DONE : RUN;
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (load_valid && ready_q) begin
                        if (!phase_q) begin
                            hi_d      = load_data;
                            phase_d   = 1'b1;
                            // a final high byte is padded with 0x00
                            word_done = load_last;
                            mem_wdata = N'({load_data, 8'h00});
                        end else begin
                            phase_d   = 1'b0;
                            word_done = 1'b1;
                            mem_wdata = N'({hi_q, load_data});
                        end
                        if (word_done) begin
                            if (wr_ptr_q == DEPTH_W) begin
                                ovf_d = 1'b1;
                            end else begin
                                mem_we   = 1'b1;
                                wr_ptr_d = wr_ptr_q + ONE;
                            end
                        end
                        if (load_last) begin
                            state_d = IDLE;
                            ready_d = 1'b0;
                        end
                    end
                end
                RUN: begin
`ifdef FEEDER_HALT_DETECT_EN
                    // the word already on the bus is checked, so it stays put
                    if (valid_q && (instr_q[N-1 -: 4] == 4'd4)) begin
                        state_d = HALT;
                    end else
`endif
                    if (fetch_pc_q == wr_ptr_q) begin
                        state_d = DONE;
                        instr_d = '0;
                        valid_d = 1'b0;
                    end else begin
                        instr_d    = mem_q[fetch_pc_q[AW-1:0]];
                        valid_d    = 1'b1;
                        fetch_pc_d = fetch_pc_q + ONE;
                    end
                end
                default: ;
            endcase
        end

`ifdef FEEDER_HALT_DETECT_EN
        halted_d = (state_d == HALT);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            wr_ptr_q   <= '0;
            fetch_pc_q <= '0;
            ovf_q      <= 1'b0;
            phase_q    <= 1'b0;
            hi_q       <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            wr_ptr_q   <= wr_ptr_d;
            fetch_pc_q <= fetch_pc_d;
            ovf_q      <= ovf_d;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
        end
    end

`ifdef FEEDER_HALT_DETECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    // program memory survives reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[AW-1:0]] <= mem_wdata;
        end
    end

    assign load_ready  = ready_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign prog_len    = wr_ptr_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_program_feeder.sv
// tb_program_feeder: randomized load/run scenarios for program_feeder,
// checked against a byte-to-word packing and replay model.
module tb_program_feeder;

    localparam int DEPTH = 64;

    typedef logic [7:0]  bq_t[$];
    typedef logic [15:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic        run;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        halted;
    logic [6:0]  prog_len;
    logic        overflow;

    int checks;
    int failures;

    logic [15:0] cap_i [0:99];
    logic        cap_v [0:99];
    logic        cap_h [0:99];

    program_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .run         (run),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .halted      (halted),
        .prog_len    (prog_len),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // model: byte stream -> stored words, prog_len, overflow
    function automatic void pack(input bq_t b, output wq_t w,
                                 output int pl, output bit ov);
        int nw;
        nw = (b.size() + 1) / 2;
        w = {};
        for (int i = 0; i < nw; i++) begin
            logic [7:0] hi, lo;
            hi = b[2*i];
            lo = (2*i + 1 < b.size()) ? b[2*i+1] : 8'h00;
            if (i < DEPTH) w.push_back({hi, lo});
        end
        pl = (nw < DEPTH) ? nw : DEPTH;
        ov = (nw > DEPTH);
    endfunction

    // model: outputs c cycles after the edge that samples run
    function automatic void expect_at(input wq_t w, input int c,
                                      output logic [15:0] ei,
                                      output logic ev, output logic eh);
        int h;
        h = -1;
`ifdef FEEDER_HALT_DETECT_EN
        for (int i = 0; i < w.size(); i++)
            if (h < 0 && w[i][15:12] == 4'd4) h = i;
`endif
        if (h >= 0 && c - 1 > h) begin
            ei = w[h]; ev = 1'b1; eh = 1'b1;
        end else if (c - 1 < w.size()) begin
            ei = w[c-1]; ev = 1'b1; eh = 1'b0;
        end else begin
            ei = 16'h0000; ev = 1'b0; eh = 1'b0;
        end
    endfunction

    function automatic void from_hex(input logic [63:0] v, input int n,
                                     output bq_t b);
        b = {};
        for (int i = 0; i < n; i++) b.push_back(v[8*(n-1-i) +: 8]);
    endfunction

    function automatic void rand_bytes(input int n, input bit no_hlt,
                                       output bq_t b);
        logic [7:0] x;
        b = {};
        for (int i = 0; i < n; i++) begin
            x = 8'($urandom);
            if (no_hlt && (i % 2 == 0) && x[7:4] == 4'd4) x[7:4] = 4'd5;
            b.push_back(x);
        end
    endfunction

    task automatic load_prog(input bq_t b, input int gap);
        int idx;
        int budget;
        bit acc;
        idx = 0;
        budget = b.size() * 20 + 50;
        @(negedge clk) load_start = 1'b1;
        @(negedge clk) load_start = 1'b0;
        while (idx < b.size() && budget > 0) begin
            load_valid = ($urandom_range(99) >= gap);
            load_data  = load_valid ? b[idx] : 8'($urandom);
            load_last  = load_valid ? (idx == b.size() - 1)
                                    : 1'($urandom_range(1));
            acc = load_valid && load_ready;
            @(negedge clk);
            if (acc) idx++;
            budget--;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        checks++;
        if (idx < b.size()) begin
            failures++;
            $display("FAIL load_timeout accepted=%0d required=%0d",
                     idx, b.size());
        end
    endtask

    task automatic run_capture(input int n);
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            cap_i[c] = instruction;
            cap_v[c] = instr_valid;
            cap_h[c] = halted;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({instruction, instr_valid, halted, load_ready} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outs got %h/%b/%b/%b required 0",
                     instruction, instr_valid, halted, load_ready);
        end
        checks++;
        if ({prog_len, overflow} !== 8'd0) begin
            failures++;
            $display("FAIL reset_len got %0d/%b required 0/0",
                     prog_len, overflow);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (load_ready !== 1'b0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_outs got rdy=%b v=%b required 0/0",
                     load_ready, instr_valid);
        end
    endtask

    task automatic test_load_run();
        bq_t b; wq_t w; int pl; bit ov;
        logic [15:0] ei; logic ev, eh;
        from_hex(64'h201221343000, 6, b);
        pack(b, w, pl, ov);
        load_prog(b, 0);
        checks++;
        if (load_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_fall got %b required 0", load_ready);
        end
        checks++;
        if (prog_len !== 7'(pl) || overflow !== ov) begin
            failures++;
            $display("FAIL load_run_len got %0d/%b required %0d/%b",
                     prog_len, overflow, pl, ov);
        end
        run_capture(6);
        for (int c = 1; c <= 6; c++) begin
            expect_at(w, c, ei, ev, eh);
            checks++;
            if ({cap_i[c], cap_v[c], cap_h[c]} !== {ei, ev, eh}) begin
                failures++;
                $display("FAIL load_run c=%0d got %h/%b/%b required %h/%b/%b",
                         c, cap_i[c], cap_v[c], cap_h[c], ei, ev, eh);
            end
        end
    endtask

    task automatic test_halt();
        bq_t b; wq_t w; int pl; bit ov;
        logic [15:0] ei; logic ev, eh;
        from_hex(64'h200540001012, 6, b);
        pack(b, w, pl, ov);
        load_prog(b, 25);
        for (int pass = 0; pass < 2; pass++) begin
            run_capture(10);
            for (int c = 1; c <= 10; c++) begin
                expect_at(w, c, ei, ev, eh);
                checks++;
                if ({cap_i[c], cap_v[c], cap_h[c]} !== {ei, ev, eh}) begin
                    failures++;
                    $display("FAIL halt p%0d c=%0d got %h/%b/%b required %h/%b/%b",
                             pass, c, cap_i[c], cap_v[c], cap_h[c], ei, ev, eh);
                end
            end
        end
    endtask

    task automatic test_odd_bytes();
        bq_t b; wq_t w; int pl; bit ov;
        logic [15:0] ei; logic ev, eh;
        from_hex(64'h200731, 3, b);
        pack(b, w, pl, ov);
        load_prog(b, 40);
        checks++;
        if (prog_len !== 7'(pl)) begin
            failures++;
            $display("FAIL odd_len got %0d required %0d", prog_len, pl);
        end
        run_capture(5);
        for (int c = 1; c <= 5; c++) begin
            expect_at(w, c, ei, ev, eh);
            checks++;
            if ({cap_i[c], cap_v[c], cap_h[c]} !== {ei, ev, eh}) begin
                failures++;
                $display("FAIL odd c=%0d got %h/%b/%b required %h/%b/%b",
                         c, cap_i[c], cap_v[c], cap_h[c], ei, ev, eh);
            end
        end
    endtask

    task automatic test_overflow();
        bq_t b; wq_t w; int pl; bit ov; int nv;
        logic [15:0] ei; logic ev, eh;
        rand_bytes(130, 1'b1, b);
        pack(b, w, pl, ov);
        load_prog(b, 20);
        checks++;
        if (prog_len !== 7'(pl) || overflow !== ov) begin
            failures++;
            $display("FAIL ovf_len got %0d/%b required %0d/%b",
                     prog_len, overflow, pl, ov);
        end
        run_capture(70);
        nv = 0;
        for (int c = 1; c <= 70; c++) begin
            expect_at(w, c, ei, ev, eh);
            if (cap_v[c] === 1'b1) nv++;
            checks++;
            if ({cap_i[c], cap_v[c], cap_h[c]} !== {ei, ev, eh}) begin
                failures++;
                $display("FAIL ovf c=%0d got %h/%b/%b required %h/%b/%b",
                         c, cap_i[c], cap_v[c], cap_h[c], ei, ev, eh);
            end
        end
        checks++;
        if (nv != DEPTH) begin
            failures++;
            $display("FAIL ovf_count got %0d required %0d", nv, DEPTH);
        end
    endtask

    task automatic test_random_loads();
        bq_t b; wq_t w; int pl; bit ov; int n;
        logic [15:0] ei; logic ev, eh;
        for (int it = 0; it < 5; it++) begin
            rand_bytes($urandom_range(1, 40), 1'b0, b);
            pack(b, w, pl, ov);
            load_prog(b, 50);
            checks++;
            if (prog_len !== 7'(pl) || overflow !== ov) begin
                failures++;
                $display("FAIL rnd%0d_len got %0d/%b required %0d/%b",
                         it, prog_len, overflow, pl, ov);
            end
            n = w.size() + 4;
            run_capture(n);
            for (int c = 1; c <= n; c++) begin
                expect_at(w, c, ei, ev, eh);
                checks++;
                if ({cap_i[c], cap_v[c], cap_h[c]} !== {ei, ev, eh}) begin
                    failures++;
                    $display("FAIL rnd%0d c=%0d got %h/%b/%b required %h/%b/%b",
                             it, c, cap_i[c], cap_v[c], cap_h[c], ei, ev, eh);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bq_t b; wq_t w; int pl; bit ov;
        logic [15:0] ei; logic ev, eh;
        rand_bytes(16, 1'b1, b);
        pack(b, w, pl, ov);
        load_prog(b, 30);
        run_capture(3);
        run_capture(12);
        for (int c = 1; c <= 12; c++) begin
            expect_at(w, c, ei, ev, eh);
            checks++;
            if ({cap_i[c], cap_v[c], cap_h[c]} !== {ei, ev, eh}) begin
                failures++;
                $display("FAIL restart c=%0d got %h/%b/%b required %h/%b/%b",
                         c, cap_i[c], cap_v[c], cap_h[c], ei, ev, eh);
            end
        end
        @(negedge clk) begin load_start = 1'b1; run = 1'b1; end
        @(negedge clk) begin load_start = 1'b0; run = 1'b0; end
        checks++;
        if (load_ready !== 1'b1 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL priority got rdy=%b v=%b required 1/0",
                     load_ready, instr_valid);
        end
        rand_bytes(10, 1'b0, b);
        pack(b, w, pl, ov);
        load_prog(b, 10);
        run_capture(9);
        for (int c = 1; c <= 9; c++) begin
            expect_at(w, c, ei, ev, eh);
            checks++;
            if ({cap_i[c], cap_v[c], cap_h[c]} !== {ei, ev, eh}) begin
                failures++;
                $display("FAIL prio_run c=%0d got %h/%b/%b required %h/%b/%b",
                         c, cap_i[c], cap_v[c], cap_h[c], ei, ev, eh);
            end
        end
    endtask

    task automatic test_abort();
        bq_t b; wq_t w; int pl; bit ov;
        logic [15:0] ei; logic ev, eh;
        rand_bytes(20, 1'b1, b);
        load_prog(b, 0);
        run_capture(3);
        @(negedge clk) load_start = 1'b1;
        @(negedge clk) load_start = 1'b0;
        checks++;
        if ({instruction, instr_valid, load_ready} !== {16'h0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL abort got %h/%b rdy=%b required 0000/0 rdy=1",
                     instruction, instr_valid, load_ready);
        end
        rand_bytes(7, 1'b0, b);
        pack(b, w, pl, ov);
        load_prog(b, 40);
        checks++;
        if (prog_len !== 7'(pl)) begin
            failures++;
            $display("FAIL abort_len got %0d required %0d", prog_len, pl);
        end
        run_capture(8);
        for (int c = 1; c <= 8; c++) begin
            expect_at(w, c, ei, ev, eh);
            checks++;
            if ({cap_i[c], cap_v[c], cap_h[c]} !== {ei, ev, eh}) begin
                failures++;
                $display("FAIL abort_run c=%0d got %h/%b/%b required %h/%b/%b",
                         c, cap_i[c], cap_v[c], cap_h[c], ei, ev, eh);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        bq_t b; wq_t w; int pl; bit ov;
        logic [15:0] ei; logic ev, eh;
        rand_bytes(12, 1'b1, b);
        load_prog(b, 0);
        run_capture(2);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({instruction, instr_valid, halted, load_ready,
             prog_len, overflow} !== 27'd0) begin
            failures++;
            $display("FAIL async_rst got %h/%b/%b/%b/%0d/%b required 0",
                     instruction, instr_valid, halted, load_ready,
                     prog_len, overflow);
        end
        @(negedge clk) rst = 1'b0;
        run_capture(4);
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({cap_i[c], cap_v[c], cap_h[c]} !== 18'd0) begin
                failures++;
                $display("FAIL empty_run c=%0d got %h/%b/%b required 0000/0/0",
                         c, cap_i[c], cap_v[c], cap_h[c]);
            end
        end
        rand_bytes(9, 1'b0, b);
        pack(b, w, pl, ov);
        load_prog(b, 30);
        run_capture(9);
        for (int c = 1; c <= 9; c++) begin
            expect_at(w, c, ei, ev, eh);
            checks++;
            if ({cap_i[c], cap_v[c], cap_h[c]} !== {ei, ev, eh}) begin
                failures++;
                $display("FAIL reload c=%0d got %h/%b/%b required %h/%b/%b",
                         c, cap_i[c], cap_v[c], cap_h[c], ei, ev, eh);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
        run        = 1'b0;
        test_reset();
        test_load_run();
        test_halt();
        test_odd_bytes();
        test_overflow();
        test_random_loads();
        test_back_to_back();
        test_abort();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
